issue_sequencer: RTL

- Decode-stage issue controller for the pipelined core. It consumes the 10-bit control rod produced by the control unit, plus the decoded register fields.
- It decides each cycle whether the instruction in ID may issue to EX. Issue is blocked by RAW hazards, tracked by an in-flight writeback scoreboard (no forwarding in the datapath), by multi-cycle MUL occupancy, and by pending branch/jump resolution.
- It drives the pipeline stall and flush controls.

---
 rtl/issue_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/issue_sequencer.sv
// Decode-stage issue controller: RAW scoreboard, MUL occupancy and branch/jump
// resolution decide whether the ID instruction may issue, and drive stall/flush.
module issue_sequencer #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [9:0]        id_control_rod,
    input  logic [REG_AW-1:0] id_rs_a,
    input  logic [REG_AW-1:0] id_rs_b,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_br_resolved,
    input  logic              ex_br_taken,
    output logic              id_ready,
    output logic              ex_issue,
    output logic              stall_o,
    output logic              flush_o,
    output logic [1:0]        state_o
);

    localparam int unsigned CntW = $clog2(MUL_CYCLES);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StMulWait  = 2'd1,
        StBrWait   = 2'd2,
        StJmpFlush = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   mul_cnt_q, mul_cnt_d;
    logic [PIPE_DEPTH-1:0] sb_valid_q, sb_valid_d;
    logic [REG_AW-1:0] sb_rd_q [PIPE_DEPTH];
    logic [REG_AW-1:0] sb_rd_d [PIPE_DEPTH];

    logic [2:0] rod_alu_op;
    logic       rod_branch;
    logic       rod_reg_write;
    logic       rod_jmp;
    logic       rod_reads_b;
    logic       rod_reads_a;
    logic       rod_is_mul;
    logic       unused_rod;

    logic hazard;
    logic ready_raw;
    logic issue_raw;

    assign rod_alu_op    = id_control_rod[2:0];
    assign rod_branch    = id_control_rod[3];
    assign rod_reg_write = id_control_rod[6];
    assign rod_jmp       = id_control_rod[7];
    assign rod_reads_b   = id_control_rod[8];
    assign rod_reads_a   = id_control_rod[9];
    assign rod_is_mul    = rod_reg_write & (rod_alu_op == 3'b010);
    // Load/store flags do not affect issue; memory hazards are resolved downstream.
    assign unused_rod    = ^id_control_rod[5:4];

    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
            if (sb_valid_q[i] &&
                ((rod_reads_a && (sb_rd_q[i] == id_rs_a)) ||
                 (rod_reads_b && (sb_rd_q[i] == id_rs_b)))) begin
                hazard = 1'b1;
            end
        end
    end

    assign ready_raw = (state_q == StRun) & ~hazard;
    assign issue_raw = id_valid & ready_raw;

    // Outputs are forced low while reset is held, independent of the clock.
    assign id_ready = rst_n & ready_raw;
    assign ex_issue = rst_n & issue_raw;
    assign stall_o  = rst_n & ((id_valid & ~ready_raw) | (state_q == StMulWait));
    assign flush_o  = rst_n & (((state_q == StBrWait) & ex_br_resolved & ex_br_taken) |
                               (state_q == StJmpFlush));
    assign state_o  = rst_n ? state_q : StRun;

    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        unique case (state_q)
            StRun: begin
                if (issue_raw) begin
                    if (rod_is_mul) begin
                        state_d   = StMulWait;
                        mul_cnt_d = CntW'(MUL_CYCLES - 1);
                    end else if (rod_branch) begin
                        state_d = StBrWait;
                    end else if (rod_jmp) begin
                        state_d = StJmpFlush;
                    end
                end
            end
            StMulWait: begin
                mul_cnt_d = mul_cnt_q - CntW'(1);
                if (mul_cnt_q == CntW'(1)) begin
                    state_d = StRun;
                end
            end
            StBrWait: begin
                if (ex_br_resolved) begin
                    state_d = StRun;
                end
            end
            StJmpFlush: begin
                state_d = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // The scoreboard ages with the pipeline; a MUL holding EX freezes it.
    always_comb begin
        sb_valid_d = sb_valid_q;
        sb_rd_d    = sb_rd_q;
        if (state_q != StMulWait) begin
            for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
                sb_valid_d[i] = sb_valid_q[i-1];
                sb_rd_d[i]    = sb_rd_q[i-1];
            end
            sb_valid_d[0] = issue_raw & rod_reg_write;
            sb_rd_d[0]    = id_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            mul_cnt_q  <= '0;
            sb_valid_q <= '0;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
                sb_rd_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            mul_cnt_q  <= mul_cnt_d;
            sb_valid_q <= sb_valid_d;
            sb_rd_q    <= sb_rd_d;
        end
    end

endmodule
